// File: rtl/cam_buf_wr.sv
// rtl/cam_buf_wr.sv - camera byte stream to ping-pong frame buffer writer
// Packs RGB565 byte pairs into pixels and commits whole frames to two alternating buffers.
module cam_buf_wr #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 272,
  localparam int TOTAL_PIXELS = IMG_W * IMG_H
) (
  input  logic        iClk,
  input  logic        wRst,
  input  logic        wEnClk,
  input  logic        wWrStart,
  input  logic        wCamVsync,
  input  logic        wCamHref,
  input  logic [7:0]  wCamDt,
  input  logic        buf0_empty_rd,
  input  logic        buf1_empty_rd,
  output logic        wOBufWrEn,
  output logic [16:0] wOBufWrAddr,
  output logic [15:0] wOBufWrDt,
  output logic        buf_sel_wr,
  output logic        buf0_full_wr,
  output logic        buf1_full_wr,
  output logic        wFrDone,
  output logic        wFrDrop
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RUN  = 2'd2;

  localparam logic [16:0] LAST_ADDR = 17'(TOTAL_PIXELS - 1);

  logic [1:0]  state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] pix_q, pix_d;
  logic        pend_q, pend_d;
  logic        sel_q, sel_d;
  logic [1:0]  full_q, full_d;
  logic        drop_q, drop_d;
  logic        vs_prev_q, href_prev_q;
  logic [1:0]  sync0_q, sync1_q, edge_q;

  logic        frame_start, vs_rise, href_rise, in_run;
  logic        wr_fire, last_wr, cur_phase;
  logic [1:0]  rd_clr;

  assign frame_start = wEnClk & vs_prev_q & ~wCamVsync;
  assign vs_rise     = wEnClk & ~vs_prev_q & wCamVsync;
  assign href_rise   = wCamHref & ~href_prev_q;
  assign in_run      = (state_q == W_RUN);
  // The assembled pixel waits in pix_q until the next enabled cycle, so the
  // strobe never appears on a cycle where the datapath is frozen.
  assign wr_fire     = pend_q & wEnClk & in_run;
  assign last_wr     = wr_fire & (cnt_q == LAST_ADDR);
  assign cur_phase   = href_rise ? 1'b0 : phase_q;
  assign rd_clr      = sync1_q & ~edge_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    pix_d   = pix_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    full_d  = full_q & ~rd_clr;

    if (wr_fire) begin
      pend_d = 1'b0;
      if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 17'd1;
    end

    case (state_q)
      W_IDLE: begin
        if (wEnClk && wWrStart) state_d = W_WAIT;
      end
      W_WAIT: begin
        if (frame_start) begin
          if (full_q[sel_q]) begin
            drop_d = 1'b1;
          end else begin
            state_d = W_RUN;
            cnt_d   = '0;
            phase_d = 1'b0;
            pend_d  = 1'b0;
          end
        end
      end
      W_RUN: begin
        // Committing the last pixel outranks a simultaneous Vsync rise; the
        // set below is applied after the reader clear so set wins.
        if (last_wr) begin
          full_d[sel_q] = 1'b1;
          sel_d         = ~sel_q;
          state_d       = W_WAIT;
        end else if (vs_rise) begin
          drop_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = W_WAIT;
        end else if (wEnClk && wCamHref) begin
          if (!cur_phase) begin
            hi_d    = wCamDt;
            phase_d = 1'b1;
          end else begin
            pix_d   = {hi_q, wCamDt};
            pend_d  = 1'b1;
            phase_d = 1'b0;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge wRst) begin
    if (wRst) begin
      state_q     <= W_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_q       <= '0;
      pend_q      <= 1'b0;
      sel_q       <= 1'b0;
      full_q      <= '0;
      drop_q      <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      sync0_q     <= '0;
      sync1_q     <= '0;
      edge_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      pix_q   <= pix_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      if (wEnClk) begin
        vs_prev_q   <= wCamVsync;
        href_prev_q <= wCamHref;
      end
      // Reader flags cross domains every clock, independent of wEnClk.
      sync0_q <= {buf1_empty_rd, buf0_empty_rd};
      sync1_q <= sync0_q;
      edge_q  <= sync1_q;
    end
  end

  assign wOBufWrEn    = wr_fire;
  assign wOBufWrAddr  = cnt_q;
  assign wOBufWrDt    = pix_q;
  assign buf_sel_wr   = sel_q;
  assign buf0_full_wr = full_q[0];
  assign buf1_full_wr = full_q[1];
  assign wFrDone      = last_wr;
  assign wFrDrop      = drop_q;

endmodule

// File: tb/tb_cam_buf_wr.sv
// tb/tb_cam_buf_wr.sv - self-checking bench for cam_buf_wr
// Frame-level reference model feeds an expected-write queue checked every cycle.
module tb_cam_buf_wr;

  localparam int W = 16;
  localparam int H = 8;
  localparam int TOTAL = W * H;

  logic        iClk, wRst, wEnClk, wWrStart, wCamVsync, wCamHref;
  logic [7:0]  wCamDt;
  logic        buf0_empty_rd, buf1_empty_rd;
  logic        wOBufWrEn;
  logic [16:0] wOBufWrAddr;
  logic [15:0] wOBufWrDt;
  logic        buf_sel_wr, buf0_full_wr, buf1_full_wr, wFrDone, wFrDrop;

  cam_buf_wr #(.IMG_W(W), .IMG_H(H)) dut (
    .iClk(iClk), .wRst(wRst), .wEnClk(wEnClk), .wWrStart(wWrStart),
    .wCamVsync(wCamVsync), .wCamHref(wCamHref), .wCamDt(wCamDt),
    .buf0_empty_rd(buf0_empty_rd), .buf1_empty_rd(buf1_empty_rd),
    .wOBufWrEn(wOBufWrEn), .wOBufWrAddr(wOBufWrAddr), .wOBufWrDt(wOBufWrDt),
    .buf_sel_wr(buf_sel_wr), .buf0_full_wr(buf0_full_wr), .buf1_full_wr(buf1_full_wr),
    .wFrDone(wFrDone), .wFrDrop(wFrDrop)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic        sel;
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int act_done = 0, act_drop = 0, exp_done = 0, exp_drop = 0;
  bit half = 1'b0;
  bit first_seen = 1'b0;
  logic [16:0] first_addr;
  logic [15:0] first_data, addr2_data;

  // Reference model: spec-level frame state
  int          m_state;
  int          m_addr;
  bit          m_phase, m_sel, m_vs_prev, m_href_prev;
  logic [1:0]  m_full;
  logic [7:0]  m_hi;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_phase = 0; m_sel = 0;
    m_vs_prev = 0; m_href_prev = 0; m_full = 2'b00; m_hi = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_sample(input bit vs, input bit href, input logic [7:0] dt);
    bit fs, vr, hr;
    wr_t e;
    fs = m_vs_prev & ~vs;
    vr = ~m_vs_prev & vs;
    hr = href & ~m_href_prev;
    if (m_state == 0) begin
      if (wWrStart) m_state = 1;
    end else if (m_state == 1) begin
      if (fs) begin
        if (m_full[m_sel]) exp_drop++;
        else begin m_state = 2; m_addr = 0; m_phase = 0; end
      end
    end else begin
      if (vr) begin
        exp_drop++;
        m_state = 1;
      end else if (href) begin
        if (hr) m_phase = 0;
        if (!m_phase) begin
          m_hi = dt; m_phase = 1;
        end else begin
          e.sel = m_sel; e.addr = 17'(m_addr); e.data = {m_hi, dt};
          exp_q.push_back(e);
          m_phase = 0;
          if (m_addr == TOTAL - 1) begin
            m_full[m_sel] = 1'b1; exp_done++; m_sel = ~m_sel; m_state = 1;
          end else m_addr++;
        end
      end
    end
    m_vs_prev = vs;
    m_href_prev = href;
  endtask

  function automatic logic [7:0] byte_at(input int f, input int l, input int j);
    if (f == 0 && l == 0 && j < 2) return (j == 0) ? 8'hAB : 8'hCD;
    return 8'((f * 37 + l * 11 + j * 5 + 3) & 255);
  endfunction

  task automatic step(input bit vs, input bit href, input logic [7:0] dt);
    if (half) begin
      wEnClk = 1'b0; wCamVsync = vs; wCamHref = href; wCamDt = 8'h5A;
      @(posedge iClk); #1;
    end
    wEnClk = 1'b1; wCamVsync = vs; wCamHref = href; wCamDt = dt;
    model_sample(vs, href, dt);
    @(posedge iClk); #1;
  endtask

  task automatic send_line(input int f, input int l, input int nb);
    for (int j = 0; j < nb; j++) step(1'b0, 1'b1, byte_at(f, l, j));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input int f, input int nlines, input int last_nb,
                       input bit odd_first, input bit extra_line);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    if (odd_first) send_line(f, 99, 5);
    for (int l = 0; l < nlines; l++) send_line(f, l, (l == nlines - 1) ? last_nb : 2 * W);
    if (extra_line) send_line(f, 50, 2 * W);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_frame_state();
    chk("done_count", act_done, exp_done);
    chk("drop_count", act_drop, exp_drop);
    chk("buf0_full", buf0_full_wr, m_full[0]);
    chk("buf1_full", buf1_full_wr, m_full[1]);
    chk("buf_sel", buf_sel_wr, m_sel);
    chk("exp_queue_drained", exp_q.size(), 0);
  endtask

  task automatic reader_release(input int b);
    if (b == 0) buf0_empty_rd = 1'b1; else buf1_empty_rd = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    chk(b == 0 ? "buf0_clear_3clk" : "buf1_clear_3clk", b == 0 ? buf0_full_wr : buf1_full_wr, 0);
    m_full[b] = 1'b0;
    buf0_empty_rd = 1'b0; buf1_empty_rd = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
  endtask

  always @(negedge iClk) begin
    if (!wRst) begin
      if (!wEnClk) begin
        checks++;
        if (wOBufWrEn) begin
          failures++;
          $display("FAIL wr_en_gated actual=1 expected=0");
        end
      end
      if (wOBufWrEn) begin
        wr_count++;
        if (!first_seen) begin
          first_seen = 1'b1; first_addr = wOBufWrAddr; first_data = wOBufWrDt;
        end
        if (wOBufWrAddr == 17'd2) addr2_data = wOBufWrDt;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h expected none", wOBufWrAddr, wOBufWrDt);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.sel !== buf_sel_wr || mon_e.addr !== wOBufWrAddr || mon_e.data !== wOBufWrDt) begin
            failures++;
            $display("FAIL write actual sel=%0d addr=%0h data=%0h expected sel=%0d addr=%0h data=%0h",
                     buf_sel_wr, wOBufWrAddr, wOBufWrDt, mon_e.sel, mon_e.addr, mon_e.data);
          end
        end
      end
      if (wFrDone) act_done++;
      if (wFrDrop) act_drop++;
    end
  end

  int wr_snap;

  initial begin
    wRst = 1'b1; wEnClk = 1'b0; wWrStart = 1'b0; wCamVsync = 1'b1; wCamHref = 1'b0;
    wCamDt = 8'h00; buf0_empty_rd = 1'b0; buf1_empty_rd = 1'b0;
    model_reset();
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_wr_en", wOBufWrEn, 0);
    chk("rst_addr", wOBufWrAddr, 0);
    chk("rst_data", wOBufWrDt, 0);
    chk("rst_sel", buf_sel_wr, 0);
    chk("rst_full0", buf0_full_wr, 0);
    chk("rst_full1", buf1_full_wr, 0);
    chk("rst_done", wFrDone, 0);
    chk("rst_drop", wFrDrop, 0);
    wRst = 1'b0;
    wWrStart = 1'b1;

    // Frame A: full frame plus trailing bytes after the last pixel
    frame(0, H, 2 * W, 1'b0, 1'b1);
    check_frame_state();
    chk("first_addr", first_addr, 0);
    chk("first_data", first_data, 16'hABCD);
    chk("frameA_writes", wr_count, 128);
    chk("frameA_full0", buf0_full_wr, 1);
    chk("frameA_sel", buf_sel_wr, 1);

    // Frame B fills buffer 1
    frame(1, H, 2 * W, 1'b0, 1'b0);
    check_frame_state();
    chk("frameB_full1", buf1_full_wr, 1);
    chk("frameB_sel", buf_sel_wr, 0);
    chk("frameB_writes", wr_count, 256);

    // Frame C: both buffers full, dropped
    frame(2, H, 2 * W, 1'b0, 1'b0);
    check_frame_state();
    chk("frameC_drop", act_drop, 1);
    chk("frameC_writes", wr_count, 256);

    reader_release(0);

    // Frame D: short frame of 10 pixels
    frame(3, 1, 20, 1'b0, 1'b0);
    check_frame_state();
    chk("frameD_drop", act_drop, 2);
    chk("frameD_full0", buf0_full_wr, 0);
    chk("frameD_sel", buf_sel_wr, 0);

    // Frame E: half-rate enable, 5-byte first line, overlong frame
    half = 1'b1;
    frame(4, H, 2 * W, 1'b1, 1'b0);
    half = 1'b0;
    check_frame_state();
    chk("frameE_realign", addr2_data, 16'h979C);
    chk("frameE_full0", buf0_full_wr, 1);
    chk("frameE_writes", wr_count, 394);

    reader_release(1);

    // Frame F: reset asserted mid-capture
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b1, byte_at(5, 0, j));
    #2;
    wRst = 1'b1;
    #1;
    chk("midrst_wr_en", wOBufWrEn, 0);
    chk("midrst_addr", wOBufWrAddr, 0);
    chk("midrst_data", wOBufWrDt, 0);
    chk("midrst_sel", buf_sel_wr, 0);
    chk("midrst_full0", buf0_full_wr, 0);
    chk("midrst_full1", buf1_full_wr, 0);
    model_reset();
    wWrStart = 1'b0; wCamHref = 1'b0; wCamVsync = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    wRst = 1'b0;
    wr_snap = wr_count;

    // Without wWrStart nothing is captured
    frame(6, H, 2 * W, 1'b0, 1'b0);
    chk("no_start_writes", wr_count, wr_snap);
    check_frame_state();

    wWrStart = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    frame(7, H, 2 * W, 1'b0, 1'b0);
    check_frame_state();
    chk("frameG_writes", wr_count - wr_snap, 128);
    chk("frameG_full0", buf0_full_wr, 1);
    chk("frameG_sel", buf_sel_wr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_buf_wr.md
CAM_BUF_WR -- requirements
Module: cam_buf_wr

Interface
REQ-001 SHALL have parameters: IMG_W default 480, active pixels per line; IMG_H default 272, active lines per frame; TOTAL_PIXELS = IMG_W*IMG_H (130560).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-high:
- iClk  in  1  system clock
- wRst  in  1  asynchronous active-high reset
- wEnClk  in  1  clock-enable qualifier; camera inputs sampled, datapath advances, only when high
- wWrStart  in  1  capture enable level, sampled in W_IDLE
- wCamVsync  in  1  high = vertical blanking
- wCamHref  in  1  high = active line byte valid
- wCamDt  in  8  camera byte, RGB565, high byte first
- buf0_empty_rd  in  1  reader finished buffer 0 (reader clock domain)
- buf1_empty_rd  in  1  reader finished buffer 1 (reader clock domain)
- wOBufWrEn  out  1  buffer write strobe
- wOBufWrAddr  out  17  pixel address 0..TOTAL_PIXELS-1
- wOBufWrDt  out  16  assembled pixel {hi,lo}
- buf_sel_wr  out  1  target buffer (0/1)
- buf0_full_wr  out  1  level, buffer 0 holds a complete frame
- buf1_full_wr  out  1  level, buffer 1 holds a complete frame
- wFrDone  out  1  one-cycle pulse, frame committed
- wFrDrop  out  1  one-cycle pulse, frame discarded

Function
REQ-003 SHALL implement FSM W_IDLE, W_WAIT, W_RUN; transitions evaluated only on wEnClk cycles.
REQ-004 W_IDLE -> W_WAIT when wWrStart=1; wWrStart otherwise ignored.
REQ-005 Frame start = wCamVsync falling edge (registered previous value, updated on wEnClk).
REQ-006 W_WAIT on frame start: if full flag of buf_sel_wr buffer is 1 -> pulse wFrDrop, stay W_WAIT; else -> W_RUN, address counter = 0, byte phase = 0.
REQ-007 W_RUN: each wEnClk cycle with wCamHref=1 toggles byte phase; phase 0 latches wCamDt as high byte; phase 1 forms pixel.
REQ-008 Byte phase SHALL reset to 0 on every wCamHref rising edge (odd-byte lines never misalign next line).
REQ-009 On phase-1 byte: next cycle wOBufWrEn=1 for exactly one cycle, wOBufWrDt={hi,wCamDt}, wOBufWrAddr=counter; counter then increments (one-cycle write latency from second byte).
REQ-010 wOBufWrEn SHALL be 0 in W_IDLE and W_WAIT and whenever wEnClk=0.
REQ-011 Write to address TOTAL_PIXELS-1: same cycle set full flag of buf_sel_wr buffer, pulse wFrDone; next cycle toggle buf_sel_wr, -> W_WAIT.
REQ-012 Bytes after the final pixel, before next frame start, SHALL be ignored.
REQ-013 wCamVsync rising in W_RUN before final pixel (short frame): pulse wFrDrop, no full flag set, buf_sel_wr unchanged, -> W_WAIT.
REQ-014 Counter SHALL never exceed TOTAL_PIXELS-1; no wrap within a frame.
REQ-015 bufN_empty_rd SHALL pass through 2-FF synchronizer plus rising-edge detect (every iClk, not gated by wEnClk); edge clears bufN_full_wr.
REQ-016 Set and clear of same full flag in same cycle: set wins.
REQ-017 Full flags SHALL be independent; both may be 1, then all frame starts drop until one clears.

Reset
REQ-018 wRst=1 SHALL asynchronously force: state W_IDLE, counter 0, byte phase 0, buf_sel_wr=0, buf0_full_wr=0, buf1_full_wr=0, wOBufWrEn=0, wOBufWrAddr=0, wOBufWrDt=0, wFrDone=0, wFrDrop=0, synchronizer and edge registers 0.
REQ-019 Reset mid-frame SHALL discard partial frame; after release, capture restarts only via W_IDLE and a new Vsync fall.

Verification
REQ-020 Full frame, wEnClk=1: wWrStart=1, Vsync fall, 272 lines x 960 bytes -> 130560 writes, addresses 0..130559, buf0_full_wr=1, one wFrDone, buf_sel_wr=1.
REQ-021 Byte packing: bytes 0xAB,0xCD -> wOBufWrDt=0xABCD at address 0, one cycle after 0xCD sampled.
REQ-022 Both full: two frames without reader empty -> third frame start pulses wFrDrop, no writes; then buf0_empty_rd rise -> buf0_full_wr=0 within 3 iClk, next frame writes buffer 0.
REQ-023 Short frame: Vsync rises after 1000 pixels -> wFrDrop pulse, full flags unchanged, next frame rewrites same buffer from address 0.
REQ-024 wEnClk at 1-in-2 cycles: identical write sequence, strobes only on enabled cycles; 5-byte line followed by new line -> phase realigned, next pixel = first two bytes of new line.
REQ-025 wRst asserted mid-W_RUN -> all outputs 0 immediately; no writes until wWrStart and next Vsync fall.
